seq_bin2bcd: RTL and testbench

Downstream stage of the sequential 16-bit adder. Consumes its registered 17-bit sum, overflow flag and level-held done flag, and converts the binary sum to packed BCD with a bit-serial double-dabble (shift-add-3) FSM, one input bit per cycle. The result feeds the display/readout path. Area stays small and matches the datapath's serial style.

---
 rtl/seq_bin2bcd_pkg.sv | 13 +
 rtl/seq_bin2bcd_digit_adj.sv | 15 +
 rtl/seq_bin2bcd.sv | 108 ++++++++++
 tb/tb_seq_bin2bcd.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_bin2bcd_pkg.sv
// Shared types and constants for the bit-serial binary-to-BCD converter.
package seq_bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_BLANK   = 4'hF;

endpackage

// File: rtl/seq_bin2bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to one BCD digit when it is >= 5.
module bcd_digit_adj
    import seq_bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5)
            digit_out = digit_in + 4'd3;
    end

endmodule

// File: rtl/seq_bin2bcd.sv
// Bit-serial double-dabble binary-to-BCD converter, one input bit per cycle.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seq_bin2bcd
    import seq_bin2bcd_pkg::*;
#(
    parameter int IN_W   = 17,
    parameter int DIGITS = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    input  logic                          in_ovf,
    output logic                          busy,
    output logic                          out_valid,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_ovf
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(IN_W - 1);

    state_t           state;
    logic             in_valid_d;
    logic             start;
    logic             ovf_cap;
    logic [IN_W-1:0]  bin_sr;
    logic [BCD_W-1:0] bcd_work;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] bcd_final;
    logic [CNT_W-1:0] counter;

    assign start = in_valid & ~in_valid_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic nz_seen;

    // Scan from the top digit down; digit 0 is always shown.
    always_comb begin
        bcd_final = bcd_work;
        nz_seen   = 1'b0;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (bcd_work[i*BCD_DIGIT_W +: BCD_DIGIT_W] != '0)
                nz_seen = 1'b1;
            if (!nz_seen)
                bcd_final[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_BLANK;
        end
    end
`else
    assign bcd_final = bcd_work;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_valid_d <= 1'b0;
            ovf_cap    <= 1'b0;
            bin_sr     <= '0;
            bcd_work   <= '0;
            counter    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_bcd    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            in_valid_d <= in_valid;
            out_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= in_data;
                        ovf_cap  <= in_ovf;
                        bcd_work <= '0;
                        counter  <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_work, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    counter            <= counter + 1'b1;
                    if (counter == LAST_SHIFT)
                        state <= DONE;
                end
                DONE: begin
                    out_bcd   <= bcd_final;
                    out_ovf   <= ovf_cap;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed self-checking bench for seq_bin2bcd; honours LEADING_ZERO_BLANK_EN.
module tb_seq_bin2bcd;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [16:0] in_data;
    logic        in_ovf;
    logic        busy;
    logic        out_valid;
    logic [23:0] out_bcd;
    logic        out_ovf;

    int vectors    = 0;
    int miscompares = 0;

    seq_bin2bcd #(.IN_W(17), .DIGITS(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .busy      (busy),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected display code for a plain zero-padded BCD value.
    function automatic logic [23:0] disp(input logic [23:0] plain);
        logic [23:0] r;
        r = plain;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 5; i >= 1; i--) begin
            if (plain[i*4 +: 4] != 4'h0) break;
            r[i*4 +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    // Raise in_valid (edge 0), drop it, then wait for out_valid with a bound.
    task automatic convert(input logic [16:0] d, input logic ovf, output int lat);
        in_data  = d;
        in_ovf   = ovf;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    int lat;
    int pulses;
    logic [23:0] seen_bcd;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_ovf   = 1'b0;
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_bcd", 32'(out_bcd), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        reset = 1'b0;
        step();

        // Zero value, latency and pulse width
        in_data  = 17'd0;
        in_ovf   = 1'b0;
        in_valid = 1'b1;
        step();
        check("busy_after_edge0", 32'(busy), 32'd1);
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("zero_latency", 32'(lat), 32'd18);
        check("zero_bcd", 32'(out_bcd), 32'(disp(24'h000000)));
        check("zero_ovf", 32'(out_ovf), 32'd0);
        step();
        check("pulse_width", 32'(out_valid), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);

        // Maximum input with overflow flag
        step();
        convert(17'd131071, 1'b1, lat);
        check("max_latency", 32'(lat), 32'd18);
        check("max_bcd", 32'(out_bcd), 32'(disp(24'h131071)));
        check("max_ovf", 32'(out_ovf), 32'd1);
        step();

        // Back-to-back requests; output holds between pulses
        convert(17'd9999, 1'b0, lat);
        check("9999_bcd", 32'(out_bcd), 32'(disp(24'h009999)));
        check("9999_ovf", 32'(out_ovf), 32'd0);
        step();
        in_data  = 17'd65536;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = 17'd1;
        repeat (10) step();
        check("hold_9999", 32'(out_bcd), 32'(disp(24'h009999)));
        lat = -1;
        for (int n = 11; n <= 40; n++) begin
            step();
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check("65536_latency", 32'(lat), 32'd18);
        check("65536_bcd", 32'(out_bcd), 32'(disp(24'h065536)));
        step();

        // Level-held in_valid with a re-rise while busy
        in_data  = 17'd42;
        in_valid = 1'b1;
        pulses   = 0;
        seen_bcd = '0;
        for (int c = 0; c < 50; c++) begin
            if (c == 3) in_valid = 1'b0;
            if (c == 5) in_valid = 1'b1;
            step();
            if (out_valid) begin
                pulses++;
                seen_bcd = out_bcd;
            end
        end
        in_valid = 1'b0;
        step();
        check("held_pulses", 32'(pulses), 32'd1);
        check("held_bcd", 32'(seen_bcd), 32'(disp(24'h000042)));
        step();

        // Reset mid-conversion aborts it
        in_data  = 17'd12345;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        pulses   = 0;
        repeat (8) step();
        check("busy_mid_shift", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_bcd_async", 32'(out_bcd), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (out_valid) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_bcd", 32'(out_bcd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        convert(17'd777, 1'b0, lat);
        check("777_latency", 32'(lat), 32'd18);
        check("777_bcd", 32'(out_bcd), 32'(disp(24'h000777)));
        step();

        // No leading zeros to blank
        convert(17'd100000, 1'b1, lat);
        check("100000_bcd", 32'(out_bcd), 32'(disp(24'h100000)));
        check("100000_ovf", 32'(out_ovf), 32'd1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
